// File: rtl/bram_loader.sv
// Streams bytes (valid/ready) or a constant fill pattern into sequential BRAM write-port addresses.
// Optional running checksum of written data is enabled by defining BRAM_LOADER_CKSUM_EN.
module bram_loader #(
    parameter int unsigned ADDR_W = 11,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 2048,
    parameter bit          WRAP   = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              fill,
    input  logic [DATA_W-1:0] fill_data,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              wr_en,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   count,
`ifdef BRAM_LOADER_CKSUM_EN
    output logic [DATA_W-1:0] cksum,
`endif
    output logic              overflow
);

    localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   LAST_CNT  = (ADDR_W+1)'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] LAST_PTR  = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_FILL,
        S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              overflow_q, overflow_d;
    logic [DATA_W-1:0] fill_val_q, fill_val_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              wr_en_q, wr_en_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              xfer;
    logic              accept;
    logic [ADDR_W-1:0] ptr_nxt;
    logic [ADDR_W:0]   count_inc;

    assign in_ready  = (state_q == S_LOAD) && (WRAP || (count_q < DEPTH_CNT));
    assign xfer      = in_valid && in_ready;
    assign accept    = (state_q == S_IDLE) && (start || fill);
    assign ptr_nxt   = (ptr_q == LAST_PTR) ? '0 : ptr_q + ADDR_W'(1);
    assign count_inc = (count_q == DEPTH_CNT) ? count_q : count_q + (ADDR_W+1)'(1);

    // Next-state and registered-output logic
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        fill_val_d = fill_val_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        wr_en_d    = 1'b0;
        done_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start || fill) begin
                    state_d    = start ? S_LOAD : S_FILL;
                    ptr_d      = '0;
                    count_d    = '0;
                    overflow_d = 1'b0;
                    if (!start) begin
                        fill_val_d = fill_data;
                    end
                end
            end
            S_LOAD: begin
                if (xfer) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = ptr_q;
                    wr_data_d = in_data;
                    ptr_d     = ptr_nxt;
                    count_d   = count_inc;
                    // count already at DEPTH means this write lands on a wrapped address
                    if (WRAP && (count_q == DEPTH_CNT)) begin
                        overflow_d = 1'b1;
                    end
                    if (in_last) begin
                        state_d = S_DONE;
                    end else if (!WRAP && (count_q == LAST_CNT)) begin
                        state_d    = S_DONE;
                        overflow_d = 1'b1;
                    end
                end
            end
            S_FILL: begin
                wr_en_d   = 1'b1;
                wr_addr_d = ptr_q;
                wr_data_d = fill_val_q;
                ptr_d     = ptr_nxt;
                count_d   = count_inc;
                if (ptr_q == LAST_PTR) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_LOAD) || (state_d == S_FILL);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            fill_val_q <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            wr_en_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            fill_val_q <= fill_val_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            wr_en_q    <= wr_en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign wr_en    = wr_en_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign count    = count_q;
    assign overflow = overflow_q;

`ifdef BRAM_LOADER_CKSUM_EN
    logic [DATA_W-1:0] cksum_q, cksum_d;

    // Accumulates each write one cycle after it appears on the port
    always_comb begin
        cksum_d = cksum_q;
        if (accept) begin
            cksum_d = '0;
        end else if (wr_en_q) begin
            cksum_d = cksum_q + wr_data_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cksum_q <= '0;
        end else begin
            cksum_q <= cksum_d;
        end
    end

    assign cksum = cksum_q;
`endif

endmodule

// File: tb/tb_bram_loader.sv
// Randomized self-checking bench for bram_loader: three instances (16/no-wrap, 4/no-wrap, 4/wrap)
// checked against a transaction-level model of accepted bytes, write addresses, flags and timing.
`timescale 1ns/1ps
module tb_bram_loader;

    localparam int unsigned AW = 11;
    localparam int unsigned DW = 8;
    localparam int          NI = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          start, fill, in_valid, in_last;
    logic [DW-1:0] fill_data, in_data;
    logic [1:0]    sel;

    logic          in_ready_a [NI];
    logic          wr_en_a    [NI];
    logic          busy_a     [NI];
    logic          done_a     [NI];
    logic          overflow_a [NI];
    logic [AW-1:0] wr_addr_a  [NI];
    logic [DW-1:0] wr_data_a  [NI];
    logic [AW:0]   count_a    [NI];
`ifdef BRAM_LOADER_CKSUM_EN
    logic [DW-1:0] cksum_a    [NI];
    logic [DW-1:0] cksum;
`endif

    logic          in_ready, wr_en, busy, done, overflow;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [AW:0]   count;

    bram_loader #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(16), .WRAP(1'b0)) u_d16 (
        .clk(clk), .reset(reset),
        .start(start && sel == 2'd0), .fill(fill && sel == 2'd0), .fill_data(fill_data),
        .in_data(in_data), .in_valid(in_valid && sel == 2'd0), .in_last(in_last),
        .in_ready(in_ready_a[0]), .wr_addr(wr_addr_a[0]), .wr_data(wr_data_a[0]),
        .wr_en(wr_en_a[0]), .busy(busy_a[0]), .done(done_a[0]), .count(count_a[0]),
`ifdef BRAM_LOADER_CKSUM_EN
        .cksum(cksum_a[0]),
`endif
        .overflow(overflow_a[0])
    );

    bram_loader #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(4), .WRAP(1'b0)) u_d4 (
        .clk(clk), .reset(reset),
        .start(start && sel == 2'd1), .fill(fill && sel == 2'd1), .fill_data(fill_data),
        .in_data(in_data), .in_valid(in_valid && sel == 2'd1), .in_last(in_last),
        .in_ready(in_ready_a[1]), .wr_addr(wr_addr_a[1]), .wr_data(wr_data_a[1]),
        .wr_en(wr_en_a[1]), .busy(busy_a[1]), .done(done_a[1]), .count(count_a[1]),
`ifdef BRAM_LOADER_CKSUM_EN
        .cksum(cksum_a[1]),
`endif
        .overflow(overflow_a[1])
    );

    bram_loader #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(4), .WRAP(1'b1)) u_d4w (
        .clk(clk), .reset(reset),
        .start(start && sel == 2'd2), .fill(fill && sel == 2'd2), .fill_data(fill_data),
        .in_data(in_data), .in_valid(in_valid && sel == 2'd2), .in_last(in_last),
        .in_ready(in_ready_a[2]), .wr_addr(wr_addr_a[2]), .wr_data(wr_data_a[2]),
        .wr_en(wr_en_a[2]), .busy(busy_a[2]), .done(done_a[2]), .count(count_a[2]),
`ifdef BRAM_LOADER_CKSUM_EN
        .cksum(cksum_a[2]),
`endif
        .overflow(overflow_a[2])
    );

    always_comb begin
        in_ready = in_ready_a[sel];
        wr_en    = wr_en_a[sel];
        busy     = busy_a[sel];
        done     = done_a[sel];
        overflow = overflow_a[sel];
        wr_addr  = wr_addr_a[sel];
        wr_data  = wr_data_a[sel];
        count    = count_a[sel];
`ifdef BRAM_LOADER_CKSUM_EN
        cksum    = cksum_a[sel];
`endif
    end

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Write/done monitor, sampled on the inactive edge
    int w_cyc[$];
    int w_addr[$];
    int w_data[$];
    int w_ovf[$];
    int d_cyc[$];
    always @(negedge clk) begin
        if (!reset) begin
            if (wr_en) begin
                w_cyc.push_back(cyc);
                w_addr.push_back(int'(wr_addr));
                w_data.push_back(int'(wr_data));
                w_ovf.push_back(int'(overflow));
            end
            if (done) d_cyc.push_back(cyc);
        end
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int dep_of(input logic [1:0] k);
        return (k == 2'd0) ? 16 : 4;
    endfunction

    function automatic bit wrap_of(input logic [1:0] k);
        return k == 2'd2;
    endfunction

    task automatic clear_mon();
        w_cyc.delete(); w_addr.delete(); w_data.delete(); w_ovf.delete(); d_cyc.delete();
    endtask

    task automatic check_end(input string tag, input int nw, input int cnt_exp, input bit ovf_exp,
                             input int sum);
        check($sformatf("%s writes", tag), w_cyc.size(), nw);
        check($sformatf("%s done_pulses", tag), d_cyc.size(), 1);
        if (d_cyc.size() > 0 && w_cyc.size() > 0)
            check($sformatf("%s done_cycle", tag), d_cyc[0], w_cyc[w_cyc.size()-1] + 1);
        check($sformatf("%s count", tag), count, cnt_exp);
        check($sformatf("%s overflow", tag), overflow, ovf_exp);
        check($sformatf("%s busy_after", tag), busy, 0);
`ifdef BRAM_LOADER_CKSUM_EN
        check($sformatf("%s cksum", tag), cksum, sum & 255);
`endif
    endtask

    // mode: 0 random valid/data, 1 valid always high, 2 valid pattern 1,0,1,1,0,1 then high
    task automatic load_session(input string tag, input int n, input bit has_last, input int mode,
                                input int base);
        logic [7:0] dq[$];
        int         hs[$];
        logic [5:0] pat;
        int         dep, acc_exp, cnt_exp, idx, steps, sum;
        bit         wrap, ovf_exp, v;
        pat  = 6'b101101;
        dep  = dep_of(sel);
        wrap = wrap_of(sel);
        for (int i = 0; i < n; i++) dq.push_back(mode == 0 ? 8'($urandom) : 8'(base + i));
        if (wrap) begin
            acc_exp = n;
            ovf_exp = n > dep;
        end else if (has_last && n <= dep) begin
            acc_exp = n;
            ovf_exp = 1'b0;
        end else begin
            acc_exp = dep;
            ovf_exp = 1'b1;
        end
        cnt_exp = (acc_exp < dep) ? acc_exp : dep;
        sum = 0;
        for (int i = 0; i < acc_exp; i++) sum += int'(dq[i]);

        clear_mon();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        idx   = 0;
        steps = 0;
        while (idx < n && steps < 4 * n + 40) begin
            if (mode == 0)                   v = ($urandom_range(0, 3) != 0);
            else if (mode == 2 && steps < 6) v = pat[5 - steps];
            else                             v = 1'b1;
            in_valid = v;
            in_data  = dq[idx];
            in_last  = has_last && (idx == n - 1);
            if (v && in_ready) begin
                hs.push_back(cyc);
                idx++;
            end
            @(negedge clk);
            steps++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (6) @(negedge clk);

        check($sformatf("%s acks", tag), hs.size(), acc_exp);
        for (int i = 0; i < w_cyc.size() && i < hs.size() && i < acc_exp; i++) begin
            check($sformatf("%s addr%0d", tag, i), w_addr[i], i % dep);
            check($sformatf("%s data%0d", tag, i), w_data[i], int'(dq[i]));
            check($sformatf("%s lat%0d", tag, i), w_cyc[i], hs[i] + 1);
            check($sformatf("%s ovf%0d", tag, i), w_ovf[i],
                  wrap ? int'(i >= dep) : int'(ovf_exp && i == acc_exp - 1));
        end
        check_end(tag, acc_exp, cnt_exp, ovf_exp, sum);
    endtask

    task automatic fill_session(input string tag, input logic [7:0] val);
        int dep, t0, rdy;
        dep = dep_of(sel);
        rdy = 0;
        clear_mon();
        @(negedge clk); fill = 1'b1; fill_data = val; t0 = cyc;
        @(negedge clk); fill = 1'b0; fill_data = 8'h00;
        for (int k = 0; k < dep + 6; k++) begin
            if (in_ready) rdy++;
            @(negedge clk);
        end
        check($sformatf("%s ready_seen", tag), rdy, 0);
        for (int i = 0; i < w_cyc.size() && i < dep; i++) begin
            check($sformatf("%s addr%0d", tag, i), w_addr[i], i);
            check($sformatf("%s data%0d", tag, i), w_data[i], int'(val));
            check($sformatf("%s cyc%0d", tag, i), w_cyc[i], t0 + 2 + i);
        end
        check_end(tag, dep, dep, 1'b0, int'(val) * dep);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; start = 1'b0; fill = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        fill_data = '0; in_data = '0; sel = 2'd0;
        repeat (3) @(negedge clk);
        check("rst wr_en", wr_en, 0);
        check("rst wr_addr", wr_addr, 0);
        check("rst wr_data", wr_data, 0);
        check("rst in_ready", in_ready, 0);
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst count", count, 0);
        check("rst overflow", overflow, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        sel = 2'd0;
        load_session("basic", 3, 1'b1, 1, 'h10);
        load_session("toggle", 4, 1'b1, 2, 'hA0);
        fill_session("fill16", 8'hA5);
        sel = 2'd1;
        load_session("trunc", 6, 1'b0, 1, 'h30);
        sel = 2'd2;
        load_session("wrap", 6, 1'b1, 1, 'h50);

        for (int r = 0; r < 14; r++) begin
            int  dep, n;
            bit  hl;
            sel = 2'($urandom_range(0, 2));
            dep = dep_of(sel);
            if ($urandom_range(0, 4) == 0) begin
                fill_session($sformatf("rfill%0d", r), 8'($urandom));
            end else begin
                if (wrap_of(sel)) begin
                    hl = 1'b1;
                    n  = $urandom_range(1, 3 * dep);
                end else begin
                    hl = ($urandom_range(0, 2) != 0);
                    n  = hl ? $urandom_range(1, dep + 4) : $urandom_range(dep, dep + 4);
                end
                load_session($sformatf("rload%0d", r), n, hl, 0, 0);
            end
        end

        // Asynchronous abort mid-load, then simultaneous start/fill
        sel = 2'd0;
        clear_mon();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0; in_valid = 1'b1; in_data = 8'h77; in_last = 1'b0;
        repeat (2) @(negedge clk);
        check("abort pre wr_en", wr_en, 1);
        check("abort pre busy", busy, 1);
        #2 reset = 1'b1;
        #1;
        check("abort wr_en", wr_en, 0);
        check("abort busy", busy, 0);
        check("abort in_ready", in_ready, 0);
        in_valid = 1'b0;
        @(negedge clk); reset = 1'b0;
        clear_mon();
        @(negedge clk); start = 1'b1; fill = 1'b1; fill_data = 8'hEE;
        @(negedge clk); start = 1'b0; fill = 1'b0; fill_data = 8'h00;
        check("both in_ready", in_ready, 1);
        check("both busy", busy, 1);
        in_valid = 1'b1; in_data = 8'h42; in_last = 1'b1;
        @(negedge clk); in_valid = 1'b0; in_last = 1'b0;
        repeat (6) @(negedge clk);
        check("both writes", w_cyc.size(), 1);
        if (w_data.size() > 0) check("both data", w_data[0], 'h42);
        check("both count", count, 1);
        check("both done", d_cyc.size(), 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
